// File: rtl/level_display_ctrl.sv
// level_display_ctrl: clocked tank-level sensor classifier with a 2-digit multiplexed
// 7-segment display.
//
// Each raw sensor bit is synchronised (2 flops) and debounced. The debounced vector is
// classified as a level (count of ones) and a status by a sticky-error FSM. Digit0 shows
// the level in decimal. Digit1 shows a status letter: L, n, F or E. Both digits show "--"
// while the FSM is in INIT.
//
// Optional feature macro: ERR_BLINK_EN. When it is defined, both digits blank on
// alternate blink half-periods while the FSM is in ERR. When it is undefined, ERR is
// shown steadily and no blink logic exists.
//
// Parameters:
//   N_SENS          number of stacked sensors (1..9), bit 0 is the lowest
//   DEB_CYCLES      consecutive differing samples needed to accept a new sensor value
//   SCAN_DIV        clocks per digit-scan slot (>= 2)
//   BLINK_DIV       clocks per blink half-period (used only with ERR_BLINK_EN)
//   SEG_ACTIVE_LOW  1: seg/an outputs are active-low, 0: active-high
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   sens     raw asynchronous sensor inputs, 1 = submerged
//   err_clr  single-cycle request to clear a latched error
//   seg      segment drive, seg[0]=a .. seg[6]=g (registered)
//   an       digit enables, an[0]=digit0, an[1]=digit1 (registered)
//   level    debounced level, holds its last valid value while in ERR
//   status   00 LOW, 01 NORMAL, 10 FULL, 11 ERROR
//   err      high while the FSM is in ERR

module level_display_ctrl #(
    parameter int unsigned N_SENS         = 3,
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_SENS-1:0]               sens,
    input  logic                            err_clr,
    output logic [6:0]                      seg,
    output logic [1:0]                      an,
    output logic [$clog2(N_SENS+1)-1:0]     level,
    output logic [1:0]                      status,
    output logic                            err
);

    localparam int unsigned LW = $clog2(N_SENS + 1);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned IW = $clog2(DEB_CYCLES + 2);
    localparam int unsigned SW = $clog2(SCAN_DIV);

    localparam logic [6:0] SegDash  = 7'h40;
    localparam logic [6:0] SegL     = 7'h38;
    localparam logic [6:0] SegN     = 7'h54;
    localparam logic [6:0] SegF     = 7'h71;
    localparam logic [6:0] SegE     = 7'h79;
    localparam logic [6:0] SegBlank = 7'h00;

    // Elaboration-time parameter legality checks.
    if (N_SENS < 1 || N_SENS > 9) begin : g_bad_n_sens
        $error("level_display_ctrl: N_SENS must be in 1..9");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("level_display_ctrl: DEB_CYCLES must be >= 1");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("level_display_ctrl: SCAN_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("level_display_ctrl: BLINK_DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        StInit,
        StLow,
        StNorm,
        StFull,
        StErr
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [N_SENS-1:0] sync1_q, sync2_q;
    logic [N_SENS-1:0] deb_q, deb_d;
    logic [CW-1:0]     deb_cnt_q [N_SENS];
    logic [CW-1:0]     deb_cnt_d [N_SENS];

    // The counter only advances on consecutive samples that disagree with the accepted
    // value; any agreeing sample restarts it, so short glitches never get through.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_SENS; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < N_SENS; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sens;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < N_SENS; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic          valid;
    logic [LW-1:0] lvl;
    state_e        class_st;

    always_comb begin
        lvl = '0;
        for (int i = 0; i < N_SENS; i++) begin
            lvl = lvl + LW'(deb_q[i]);
        end
        // Thermometer check: a wet sensor above a dry one is physically impossible.
        valid = 1'b1;
        for (int i = 1; i < N_SENS; i++) begin
            if (deb_q[i] && !deb_q[i-1]) begin
                valid = 1'b0;
            end
        end
    end

    always_comb begin
        if (!valid) begin
            class_st = StErr;
        end else if (lvl == '0) begin
            class_st = StLow;
        end else if (lvl == LW'(N_SENS)) begin
            class_st = StFull;
        end else begin
            class_st = StNorm;
        end
    end

    // ------------------------------------------------------------------
    // Status FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    status_q, status_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        level_d    = level_q;
        status_d   = status_q;
        err_d      = err_q;

        case (state_q)
            StInit: begin
                // Wait for the synchroniser and debouncer to fill before classifying.
                if (init_cnt_q == IW'(DEB_CYCLES + 1)) begin
                    state_d = class_st;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            StLow, StNorm, StFull: begin
                state_d = class_st;
            end
            StErr: begin
                if (err_clr && valid) begin
                    state_d = class_st;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Outputs are registered alongside the state they describe.
        case (state_d)
            StInit: begin
                level_d  = '0;
                status_d = 2'b00;
                err_d    = 1'b0;
            end
            StLow: begin
                level_d  = lvl;
                status_d = 2'b00;
                err_d    = 1'b0;
            end
            StNorm: begin
                level_d  = lvl;
                status_d = 2'b01;
                err_d    = 1'b0;
            end
            StFull: begin
                level_d  = lvl;
                status_d = 2'b10;
                err_d    = 1'b0;
            end
            StErr: begin
                status_d = 2'b11;
                err_d    = 1'b1;
            end
            default: begin
                level_d  = '0;
                status_d = 2'b00;
                err_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            level_q    <= '0;
            status_q   <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            level_q    <= level_d;
            status_q   <= status_d;
            err_q      <= err_d;
        end
    end

    assign level  = level_q;
    assign status = status_q;
    assign err    = err_q;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [SW-1:0] scan_q, scan_d;
    logic          dig_sel_q, dig_sel_d;

    always_comb begin
        dig_sel_d = dig_sel_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d    = '0;
            dig_sel_d = ~dig_sel_q;
        end else begin
            scan_d = scan_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q    <= '0;
            dig_sel_q <= 1'b0;
        end else begin
            scan_q    <= scan_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Error blink
    // ------------------------------------------------------------------
    logic blank;

`ifdef ERR_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blank = (state_q == StErr) && blink_q;
`else
    assign blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Segment / anode output stage
    // ------------------------------------------------------------------
    function automatic logic [6:0] digit_pat(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SegDash;
        endcase
        return p;
    endfunction

    logic [6:0] pat0, pat1, pat;
    logic [1:0] an_raw;
    logic [6:0] seg_d, seg_q;
    logic [1:0] an_d, an_q;

    always_comb begin
        pat0 = (state_q == StInit) ? SegDash : digit_pat(4'(level_q));

        case (state_q)
            StLow:   pat1 = SegL;
            StNorm:  pat1 = SegN;
            StFull:  pat1 = SegF;
            StErr:   pat1 = SegE;
            default: pat1 = SegDash;
        endcase

        pat = dig_sel_q ? pat1 : pat0;
        if (blank) begin
            pat = SegBlank;
        end

        an_raw = dig_sel_q ? 2'b10 : 2'b01;

        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~pat;
            an_d  = ~an_raw;
        end else begin
            seg_d = pat;
            an_d  = an_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= (SEG_ACTIVE_LOW != 0) ? ~SegDash : SegDash;
            an_q  <= (SEG_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
